// File: rtl/conv_window_reader_if.sv
// Handshake and tap bundle between the line buffers, the window reader and the
// downstream consumer of 3x3 windows.
interface conv_window_reader_if #(
    parameter int WIDTH = 8
);
    logic                 i_row_ready;
    logic [3*WIDTH-1:0]   i_row0;
    logic [3*WIDTH-1:0]   i_row1;
    logic [3*WIDTH-1:0]   i_row2;
    logic                 o_rd_en;
    logic [9*WIDTH-1:0]   o_window;
    logic                 o_valid;
    logic                 i_ready;

    // master: the window reader; slave: buffers plus downstream consumer
    modport master (
        input  i_row_ready, i_row0, i_row1, i_row2, i_ready,
        output o_rd_en, o_window, o_valid
    );
    modport slave (
        output i_row_ready, i_row0, i_row1, i_row2, i_ready,
        input  o_rd_en, o_window, o_valid
    );
endinterface

// File: rtl/conv_window_reader.sv
// Read-side controller for the three row line buffers: walks one row per pass,
// emits registered 3x3 windows and realigns the buffers with two skip reads.
module conv_window_reader #(
    parameter int COLS     = 6,
    parameter int WIDTH    = 8,
    parameter int ROWS_OUT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    conv_window_reader_if.master bus,
    output logic                 o_row_done,
    output logic                 o_frame_done,
    output logic                 o_busy
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS_OUT + 1);
    localparam logic [CW-1:0] COL_LAST_EMIT = CW'(COLS - 3);
    localparam logic [CW-1:0] COL_LAST_SKIP = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS_OUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT_ROW, EMIT, SKIP, ROW_END} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       col_cnt;
    logic [RW-1:0]       row_cnt;
    logic [9*WIDTH-1:0]  window_p0;
    logic                vld_p0;
    logic                rd_en, capture, accept;
    logic                col_clr, col_inc, row_clr, row_inc;

    assign accept       = vld_p0 && bus.i_ready;
    assign bus.o_rd_en  = rd_en;
    assign bus.o_window = window_p0;
    assign bus.o_valid  = vld_p0;
    assign o_busy       = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rd_en        = 1'b0;
        capture      = 1'b0;
        col_clr      = 1'b0;
        col_inc      = 1'b0;
        row_clr      = 1'b0;
        row_inc      = 1'b0;
        o_row_done   = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    row_clr   = 1'b1;
                    state_nxt = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (bus.i_row_ready) begin
                    col_clr   = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (!vld_p0 || bus.i_ready) begin
                    capture = 1'b1;
                    rd_en   = 1'b1;
                    col_inc = 1'b1;
                    if (col_cnt == COL_LAST_EMIT) state_nxt = SKIP;
                end
            end
            SKIP: begin
                // Skip reads ignore back-pressure so every row costs exactly COLS reads
                rd_en   = 1'b1;
                col_inc = 1'b1;
                if (col_cnt == COL_LAST_SKIP) state_nxt = ROW_END;
            end
            ROW_END: begin
                if (!vld_p0 || bus.i_ready) begin
                    o_row_done = 1'b1;
                    row_inc    = 1'b1;
                    if (row_cnt == ROW_LAST) begin
                        o_frame_done = 1'b1;
                        state_nxt    = IDLE;
                    end else begin
                        state_nxt = WAIT_ROW;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if (col_clr)      col_cnt <= '0;
            else if (col_inc) col_cnt <= col_cnt + CW'(1);
            if (row_clr)      row_cnt <= '0;
            else if (row_inc) row_cnt <= row_cnt + RW'(1);
        end
    end

    // Stage p0: output window register; a capture and an accept in the same
    // cycle keep the window stream bubble-free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            window_p0 <= '0;
            vld_p0    <= 1'b0;
        end else if (capture) begin
            window_p0 <= {bus.i_row0, bus.i_row1, bus.i_row2};
            vld_p0    <= 1'b1;
        end else if (accept) begin
            vld_p0    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader with a pointer-driven line-buffer model.
module tb_conv_window_reader;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_start = 1'b0;
    logic o_row_done, o_frame_done, o_busy;
    logic [2:0] ptr;

    conv_window_reader_if #(.WIDTH(8)) bus ();

    conv_window_reader #(.COLS(6), .WIDTH(8), .ROWS_OUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .bus(bus),
        .o_row_done(o_row_done), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [71:0] W [4] = '{
        72'h010203111213212223, 72'h020304121314222324,
        72'h030405131415232425, 72'h040506141516242526};

    // Three buffers holding 01..06, 11..16, 21..26; taps sit at the read pointer
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr <= 3'd0;
        else if (bus.o_rd_en) ptr <= (ptr == 3'd5) ? 3'd0 : ptr + 3'd1;
    end
    assign bus.i_row0 = {8'h01 + 8'(ptr), 8'h02 + 8'(ptr), 8'h03 + 8'(ptr)};
    assign bus.i_row1 = {8'h11 + 8'(ptr), 8'h12 + 8'(ptr), 8'h13 + 8'(ptr)};
    assign bus.i_row2 = {8'h21 + 8'(ptr), 8'h22 + 8'(ptr), 8'h23 + 8'(ptr)};

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, rd_cnt = 0, rowd_cnt = 0, framed_cnt = 0, frame_at_row = 0;
    int last_rd_cyc = 0, first_rowd_cyc = 0, first_row_last_rd = 0;
    logic [71:0] acc_q [$];
    int acc_cyc_q [$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (bus.o_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (bus.o_valid && bus.i_ready) begin
                acc_q.push_back(bus.o_window);
                acc_cyc_q.push_back(cyc);
            end
            if (o_row_done) begin
                rowd_cnt++;
                if (rowd_cnt == 1) begin
                    first_rowd_cyc    = cyc;
                    first_row_last_rd = last_rd_cyc;
                end
            end
            if (o_frame_done) begin
                framed_cnt++;
                frame_at_row = o_row_done ? rowd_cnt : -1;
            end
        end
    end

    task automatic do_reset(input logic rdy, input logic rrdy);
        i_rst = 1'b1;
        i_start = 1'b0;
        bus.i_ready = rdy;
        bus.i_row_ready = rrdy;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        rd_cnt = 0; rowd_cnt = 0; framed_cnt = 0; frame_at_row = 0;
        acc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge i_clk); #1; i_start = 1'b1;
        @(posedge i_clk); #1; i_start = 1'b0;
    endtask

    task automatic wait_rows(input int n, input int budget, input string tag);
        int k = 0;
        while (rowd_cnt < n && k < budget) begin
            @(negedge i_clk); #1;
            k++;
        end
        total_cnt++;
        if (rowd_cnt < n) $display("FAIL %s_timeout: row_done count %0d, required %0d", tag, rowd_cnt, n);
        else pass_cnt++;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (!bus.o_valid && k < budget) begin
            @(negedge i_clk); #1;
            k++;
        end
        total_cnt++;
        if (!bus.o_valid) $display("FAIL %s_valid_timeout: o_valid never rose", tag);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [76:0] outs;
        do_reset(1'b1, 1'b1);
        #1;
        outs = {bus.o_rd_en, bus.o_valid, o_row_done, o_frame_done, o_busy, bus.o_window};
        total_cnt++;
        if (outs !== 77'd0) $display("FAIL reset_outputs: got %h, required 0", outs);
        else pass_cnt++;
        pulse_start();
        wait_valid(20, "reset");
        #2;
        i_rst = 1'b1;
        #1;
        outs = {bus.o_rd_en, bus.o_valid, o_row_done, o_frame_done, o_busy, bus.o_window};
        total_cnt++;
        if (outs !== 77'd0) $display("FAIL reset_mid_emit: got %h, required 0", outs);
        else pass_cnt++;
        total_cnt++;
        if (rowd_cnt != 0 || framed_cnt != 0) $display("FAIL reset_no_done: rows %0d frames %0d, required 0 0", rowd_cnt, framed_cnt);
        else pass_cnt++;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        rd_cnt = 0; acc_q.delete(); acc_cyc_q.delete();
        pulse_start();
        wait_rows(1, 40, "reset_clean");
        total_cnt++;
        if (acc_q.size() != 4 || acc_q[0] !== W[0] || acc_q[3] !== W[3] || rd_cnt != 6)
            $display("FAIL reset_clean_row: windows %0d rd %0d, required 4 windows W0..W3 and 6 rd", acc_q.size(), rd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_full_row();
        do_reset(1'b1, 1'b1);
        pulse_start();
        wait_rows(1, 40, "full_row");
        total_cnt++;
        if (acc_q.size() != 4) $display("FAIL full_row_count: got %0d windows, required 4", acc_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (acc_q.size() <= i || acc_q[i] !== W[i])
                $display("FAIL full_row_win%0d: got %h, required %h", i, (acc_q.size() > i) ? acc_q[i] : 72'hx, W[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (rd_cnt != 6) $display("FAIL full_row_rd: got %0d rd_en pulses, required 6", rd_cnt);
        else pass_cnt++;
        total_cnt++;
        if (first_rowd_cyc != first_row_last_rd + 1)
            $display("FAIL full_row_done_timing: row_done cycle %0d, required %0d", first_rowd_cyc, first_row_last_rd + 1);
        else pass_cnt++;
        total_cnt++;
        if (acc_cyc_q.size() < 4 || acc_cyc_q[3] - acc_cyc_q[0] != 3)
            $display("FAIL back_to_back: 4 windows took %0d cycles, required 3", (acc_cyc_q.size() >= 4) ? acc_cyc_q[3] - acc_cyc_q[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        do_reset(1'b0, 1'b1);
        pulse_start();
        wait_valid(20, "bp");
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.o_window !== W[0] || bus.o_rd_en !== 1'b0)
                $display("FAIL bp_stall%0d: window %h rd_en %b, required %h rd_en 0", i, bus.o_window, bus.o_rd_en, W[0]);
            else pass_cnt++;
            if (i < 2) begin
                @(negedge i_clk); #1;
            end
        end
        @(posedge i_clk); #1;
        bus.i_ready = 1'b1;
        wait_rows(1, 40, "bp");
        total_cnt++;
        if (acc_q.size() != 4 || acc_q[0] !== W[0] || acc_q[1] !== W[1] || acc_q[2] !== W[2] || acc_q[3] !== W[3])
            $display("FAIL bp_sequence: got %0d windows, required W0..W3 in order", acc_q.size());
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt != 6) $display("FAIL bp_rd: got %0d rd_en pulses, required 6", rd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_row_gating();
        int bad = 0;
        int k = 0;
        do_reset(1'b1, 1'b0);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk); #1;
            if ({o_busy, bus.o_rd_en, bus.o_valid} !== 3'b100) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL row_gating_hold: %0d bad cycles, required busy=1 rd_en=0 valid=0", bad);
        else pass_cnt++;
        @(posedge i_clk); #1;
        bus.i_row_ready = 1'b1;
        while (!bus.o_rd_en && k < 5) begin
            @(negedge i_clk); #1;
            k++;
        end
        total_cnt++;
        if (!bus.o_rd_en) $display("FAIL row_gating_release: rd_en %b, required 1", bus.o_rd_en);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        int k = 0;
        int bad = 0;
        do_reset(1'b1, 1'b1);
        pulse_start();
        while (framed_cnt == 0 && k < 500) begin
            @(posedge i_clk); #1;
            bus.i_ready = 1'($urandom_range(0, 1));
            @(negedge i_clk); #1;
            k++;
        end
        bus.i_ready = 1'b1;
        total_cnt++;
        if (framed_cnt != 1) $display("FAIL frame_done_count: got %0d, required 1", framed_cnt);
        else pass_cnt++;
        total_cnt++;
        if (acc_q.size() != 16) $display("FAIL frame_windows: got %0d, required 16", acc_q.size());
        else pass_cnt++;
        foreach (acc_q[i]) if (acc_q[i] !== W[i % 4]) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL frame_sequence: %0d windows out of order, required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt != 24) $display("FAIL frame_rd: got %0d rd_en pulses, required 24", rd_cnt);
        else pass_cnt++;
        total_cnt++;
        if (rowd_cnt != 4 || frame_at_row != 4)
            $display("FAIL frame_row_done: rows %0d frame_at_row %0d, required 4 4", rowd_cnt, frame_at_row);
        else pass_cnt++;
        @(negedge i_clk); #1;
        total_cnt++;
        if (o_busy !== 1'b0) $display("FAIL frame_idle: o_busy %b, required 0", o_busy);
        else pass_cnt++;
    endtask

    task automatic test_ignored_start();
        int k = 0;
        int bad = 0;
        do_reset(1'b1, 1'b1);
        pulse_start();
        wait_valid(20, "ign");
        pulse_start();
        while (framed_cnt == 0 && k < 300) begin
            @(negedge i_clk); #1;
            k++;
        end
        foreach (acc_q[i]) if (acc_q[i] !== W[i % 4]) bad++;
        total_cnt++;
        if (acc_q.size() != 16 || bad != 0 || rd_cnt != 24 || rowd_cnt != 4 || framed_cnt != 1)
            $display("FAIL ignored_start: windows %0d bad %0d rd %0d rows %0d frames %0d, required 16 0 24 4 1",
                     acc_q.size(), bad, rd_cnt, rowd_cnt, framed_cnt);
        else pass_cnt++;
    endtask

    initial begin
        bus.i_ready = 1'b1;
        bus.i_row_ready = 1'b1;
        test_reset();
        test_full_row();
        test_back_pressure();
        test_row_gating();
        test_full_frame();
        test_ignored_start();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
